// File: rtl/scan_chain_driver_pkg.sv
// scan_chain_driver_pkg: shared state encoding and derived chain constants for the scan chain driver.
package scan_chain_driver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUIESCE,
        ST_LOAD,
        ST_SHIFT,
        ST_EMIT,
        ST_FINISH
    } state_t;

    localparam int DEF_CHAIN_LEN = 288;

    function automatic int n_bytes(input int len);
        return (len + 7) / 8;
    endfunction

    // A chain that is a whole number of bytes has a full last byte, hence 8 rather than 0.
    function automatic int last_bits(input int len);
        return (len % 8 == 0) ? 8 : len % 8;
    endfunction

    localparam int N_BYTES   = n_bytes(DEF_CHAIN_LEN);
    localparam int LAST_BITS = last_bits(DEF_CHAIN_LEN);

endpackage

// File: rtl/scan_chain_driver_serializer.sv
// scan_byte_serializer: one byte of shift-out / capture-in with a per-byte bit counter.
module scan_byte_serializer
    import scan_chain_driver_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic [3:0] load_bits,
    input  logic       step,
    input  logic       serial_in,
    output logic       serial_out,
    output logic [7:0] cap_byte,
    output logic       done
);
    logic [7:0] shift_byte;
    logic [3:0] bit_idx;
    logic [3:0] n_bits;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            shift_byte <= '0;
            cap_byte   <= '0;
            bit_idx    <= '0;
            n_bits     <= '0;
        end else if (load) begin
            shift_byte <= load_data;
            cap_byte   <= '0;
            bit_idx    <= '0;
            n_bits     <= load_bits;
        end else if (step) begin
            cap_byte[bit_idx[2:0]] <= serial_in;
            shift_byte             <= shift_byte >> 1;
            bit_idx                <= bit_idx + 4'd1;
        end

    assign serial_out = shift_byte[0];
    assign done       = step && (bit_idx == n_bits - 4'd1);

endmodule

// File: rtl/scan_chain_driver.sv
// scan_chain_driver: swaps a full scan chain against a byte stream, halting the processor meanwhile.
module scan_chain_driver
    import scan_chain_driver_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       run_after,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       scan_enable,
    output logic       scan_in,
    input  logic       scan_out,
    output logic       proc_en,
    output logic       busy,
    output logic       done
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int RW    = (CNT_W < 4) ? 4 : CNT_W;

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic [RW-1:0]    rem_x;
    logic             run_lat;
    logic             ser_load;
    logic             ser_step;
    logic             ser_done;
    logic [3:0]       load_bits;

    assign rem_x     = RW'(remaining);
    assign load_bits = (rem_x >= RW'(8)) ? 4'd8 : rem_x[3:0];
    assign ser_load  = (state == ST_LOAD) && in_valid;
    assign ser_step  = (state == ST_SHIFT);

    scan_byte_serializer u_ser (
        .clk        (clk),
        .rst        (rst),
        .load       (ser_load),
        .load_data  (in_data),
        .load_bits  (load_bits),
        .step       (ser_step),
        .serial_in  (scan_out),
        .serial_out (scan_in),
        .cap_byte   (out_data),
        .done       (ser_done)
    );

    // Outputs are set on the transition into the state that owns them, so each is a plain flop.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= ST_IDLE;
            remaining   <= '0;
            run_lat     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            scan_enable <= 1'b0;
            proc_en     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE:
                    if (start) begin
                        run_lat   <= run_after;
                        proc_en   <= 1'b0;
                        busy      <= 1'b1;
                        remaining <= CNT_W'(CHAIN_LEN);
                        state     <= ST_QUIESCE;
                    end
                ST_QUIESCE: begin
                    in_ready <= 1'b1;
                    state    <= ST_LOAD;
                end
                ST_LOAD:
                    if (in_valid) begin
                        in_ready    <= 1'b0;
                        scan_enable <= 1'b1;
                        state       <= ST_SHIFT;
                    end
                ST_SHIFT: begin
                    remaining <= remaining - CNT_W'(1);
                    if (ser_done) begin
                        scan_enable <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= ST_EMIT;
                    end
                end
                ST_EMIT:
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (remaining == '0) begin
                            done    <= 1'b1;
                            proc_en <= run_lat;
                            state   <= ST_FINISH;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= ST_LOAD;
                        end
                    end
                ST_FINISH: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end

endmodule

// File: tb/tb_scan_chain_driver.sv
// tb_scan_chain_driver: directed tests of scan_chain_driver against a behavioural scan chain.
module tb_scan_chain_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start = 0, run_after = 0, in_valid = 0, out_ready = 0;
    logic [7:0] in_data = 0;
    logic       in_ready, out_valid, scan_enable, scan_in, scan_out, proc_en, busy, done;
    logic [7:0] out_data;
    logic [11:0] chain_a = 12'h000;

    logic       b_start = 0, b_run_after = 0, b_in_valid = 0, b_out_ready = 0;
    logic [7:0] b_in_data = 0;
    logic       b_in_ready, b_out_valid, b_scan_enable, b_scan_in, b_scan_out, b_proc_en, b_busy, b_done;
    logic [7:0] b_out_data;
    logic [15:0] chain_b = 16'h0000;

    int n_cmp = 0;
    int n_err = 0;

    scan_chain_driver #(.CHAIN_LEN(12)) dut (
        .clk(clk), .rst(rst), .start(start), .run_after(run_after),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out),
        .proc_en(proc_en), .busy(busy), .done(done)
    );

    scan_chain_driver #(.CHAIN_LEN(16)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .run_after(b_run_after),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .scan_enable(b_scan_enable), .scan_in(b_scan_in), .scan_out(b_scan_out),
        .proc_en(b_proc_en), .busy(b_busy), .done(b_done)
    );

    // Model chains: scan_in enters at the top bit, scan_out is bit 0.
    assign scan_out   = chain_a[0];
    assign b_scan_out = chain_b[0];
    always @(posedge clk) if (scan_enable) chain_a <= {scan_in, chain_a[11:1]};
    always @(posedge clk) if (b_scan_enable) chain_b <= {b_scan_in, chain_b[15:1]};

    task automatic do_swap(input logic [7:0] b0, input logic [7:0] b1, input int vstall, input int ostall,
                           input int restart_at, input logic ra,
                           output logic [7:0] o0, output logic [7:0] o1, output int cycles, output int dones,
                           output int nout, output int se_bad, output logic pe_first, output logic pe_done);
        int ki, vw, ow;
        logic [7:0] ob [2];
        ki = 0; vw = 0; ow = 0; nout = 0; cycles = 0; dones = 0; se_bad = 0;
        pe_first = 1'b0; pe_done = 1'b0; ob[0] = 8'h00; ob[1] = 8'h00;
        @(negedge clk); start = 1; run_after = ra;
        @(negedge clk); start = 0;
        for (int c = 0; c < 400; c++) begin
            if (c == 0) pe_first = proc_en;
            if (busy) cycles++;
            if (done) begin dones++; pe_done = proc_en; end
            if (scan_enable && (in_ready || out_valid)) se_bad++;
            if (dones > 0 && !busy) break;
            start = (c == restart_at);
            if (in_ready && ki < 2) begin
                if (vw < vstall) begin in_valid = 0; vw++; end
                else begin in_valid = 1; in_data = (ki == 0) ? b0 : b1; ki++; end
            end else in_valid = 0;
            if (out_valid) begin
                if (ow < ostall) begin out_ready = 0; ow++; end
                else begin out_ready = 1; if (nout < 2) ob[nout] = out_data; nout++; end
            end else out_ready = 0;
            @(negedge clk);
        end
        o0 = ob[0]; o1 = ob[1];
        start = 0; in_valid = 0; out_ready = 0;
    endtask

    task automatic test_reset();
        @(negedge clk); #2 rst = 1; #1;
        if (busy !== 1'b0)        begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        if (scan_enable !== 1'b0) begin n_err++; $display("FAIL reset_scan_enable got %b want 0", scan_enable); end
        if (scan_in !== 1'b0)     begin n_err++; $display("FAIL reset_scan_in got %b want 0", scan_in); end
        if (proc_en !== 1'b0)     begin n_err++; $display("FAIL reset_proc_en got %b want 0", proc_en); end
        if (done !== 1'b0)        begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        if (in_ready !== 1'b0)    begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        if (out_valid !== 1'b0)   begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (out_data !== 8'h00)   begin n_err++; $display("FAIL reset_out_data got %h want 00", out_data); end
        n_cmp += 8;
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL idle_in_ready got %b want 0", in_ready); end
        n_cmp++;
    endtask

    task automatic test_swap();
        logic [7:0] o0, o1; int cyc, dn, no, sb; logic pf, pd;
        chain_a <= 12'hABC;
        @(negedge clk);
        do_swap(8'h5A, 8'h03, 0, 0, -1, 1'b0, o0, o1, cyc, dn, no, sb, pf, pd);
        if (chain_a !== 12'h35A) begin n_err++; $display("FAIL swap_chain got %h want 35a", chain_a); end
        if (o0 !== 8'hBC)        begin n_err++; $display("FAIL swap_out0 got %h want bc", o0); end
        if (o1 !== 8'h0A)        begin n_err++; $display("FAIL swap_out1 got %h want 0a", o1); end
        if (dn !== 1)            begin n_err++; $display("FAIL swap_done_count got %0d want 1", dn); end
        if (cyc !== 18)          begin n_err++; $display("FAIL swap_cycles got %0d want 18", cyc); end
        if (sb !== 0)            begin n_err++; $display("FAIL swap_scan_enable_idle got %0d want 0", sb); end
        n_cmp += 6;
    endtask

    task automatic test_backpressure();
        logic [7:0] o0, o1; int cyc, dn, no, sb; logic pf, pd;
        chain_a <= 12'hABC;
        @(negedge clk);
        do_swap(8'h5A, 8'h03, 3, 5, -1, 1'b0, o0, o1, cyc, dn, no, sb, pf, pd);
        if (chain_a !== 12'h35A) begin n_err++; $display("FAIL bp_chain got %h want 35a", chain_a); end
        if (o0 !== 8'hBC)        begin n_err++; $display("FAIL bp_out0 got %h want bc", o0); end
        if (o1 !== 8'h0A)        begin n_err++; $display("FAIL bp_out1 got %h want 0a", o1); end
        if (cyc !== 26)          begin n_err++; $display("FAIL bp_cycles got %0d want 26", cyc); end
        if (sb !== 0)            begin n_err++; $display("FAIL bp_scan_enable_in_stall got %0d want 0", sb); end
        n_cmp += 5;
    endtask

    task automatic test_run_after();
        logic [7:0] o0, o1; int cyc, dn, no, sb; logic pf, pd; logic [11:0] prev;
        prev = chain_a;
        do_swap(8'h11, 8'h0F, 0, 0, -1, 1'b1, o0, o1, cyc, dn, no, sb, pf, pd);
        if (pf !== 1'b0)  begin n_err++; $display("FAIL ra1_proc_en_during got %b want 0", pf); end
        if (pd !== 1'b1)  begin n_err++; $display("FAIL ra1_proc_en_at_done got %b want 1", pd); end
        if (proc_en !== 1'b1) begin n_err++; $display("FAIL ra1_proc_en_after got %b want 1", proc_en); end
        if (o0 !== prev[7:0]) begin n_err++; $display("FAIL ra1_out0 got %h want %h", o0, prev[7:0]); end
        if (o1 !== {4'h0, prev[11:8]}) begin n_err++; $display("FAIL ra1_out1 got %h want %h", o1, {4'h0, prev[11:8]}); end
        if (chain_a !== 12'hF11) begin n_err++; $display("FAIL ra1_chain got %h want f11", chain_a); end
        n_cmp += 6;
        do_swap(8'h22, 8'h01, 0, 0, -1, 1'b0, o0, o1, cyc, dn, no, sb, pf, pd);
        if (pf !== 1'b0)  begin n_err++; $display("FAIL ra0_proc_en_drop got %b want 0", pf); end
        if (pd !== 1'b0)  begin n_err++; $display("FAIL ra0_proc_en_at_done got %b want 0", pd); end
        if (o0 !== 8'h11) begin n_err++; $display("FAIL ra0_out0 got %h want 11", o0); end
        n_cmp += 3;
    endtask

    task automatic test_start_while_busy();
        logic [7:0] o0, o1; int cyc, dn, no, sb, extra; logic pf, pd;
        extra = 0;
        do_swap(8'h77, 8'h05, 0, 0, 4, 1'b0, o0, o1, cyc, dn, no, sb, pf, pd);
        for (int c = 0; c < 20; c++) begin
            if (done || busy) extra++;
            @(negedge clk);
        end
        if (dn !== 1)    begin n_err++; $display("FAIL busy_start_done_count got %0d want 1", dn); end
        if (no !== 2)    begin n_err++; $display("FAIL busy_start_out_bytes got %0d want 2", no); end
        if (extra !== 0) begin n_err++; $display("FAIL busy_start_restarted got %0d want 0", extra); end
        if (chain_a !== 12'h577) begin n_err++; $display("FAIL busy_start_chain got %h want 577", chain_a); end
        n_cmp += 4;
    endtask

    task automatic test_reset_mid_shift();
        logic [7:0] o0, o1; int cyc, dn, no, sb; logic pf, pd; logic [11:0] prev;
        @(negedge clk); start = 1; run_after = 1;
        @(negedge clk); start = 0;
        for (int c = 0; c < 20 && !in_ready; c++) @(negedge clk);
        in_valid = 1; in_data = 8'hC3;
        @(negedge clk); in_valid = 0;
        repeat (5) @(negedge clk);
        if (scan_enable !== 1'b1) begin n_err++; $display("FAIL mid_shift_scan_enable got %b want 1", scan_enable); end
        n_cmp++;
        #2 rst = 1; #1;
        if (busy !== 1'b0)        begin n_err++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        if (scan_enable !== 1'b0) begin n_err++; $display("FAIL mid_rst_scan_enable got %b want 0", scan_enable); end
        if (scan_in !== 1'b0)     begin n_err++; $display("FAIL mid_rst_scan_in got %b want 0", scan_in); end
        if (out_data !== 8'h00)   begin n_err++; $display("FAIL mid_rst_out_data got %h want 00", out_data); end
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || proc_en !== 1'b0) begin
            n_err++; $display("FAIL mid_rst_handshake got %b%b%b%b want 0000", in_ready, out_valid, done, proc_en);
        end
        n_cmp += 5;
        @(negedge clk); rst = 0;
        @(negedge clk);
        prev = chain_a;
        do_swap(8'h96, 8'h0E, 0, 0, -1, 1'b0, o0, o1, cyc, dn, no, sb, pf, pd);
        if (o0 !== prev[7:0]) begin n_err++; $display("FAIL post_rst_out0 got %h want %h", o0, prev[7:0]); end
        if (o1 !== {4'h0, prev[11:8]}) begin n_err++; $display("FAIL post_rst_out1 got %h want %h", o1, {4'h0, prev[11:8]}); end
        if (chain_a !== 12'hE96) begin n_err++; $display("FAIL post_rst_chain got %h want e96", chain_a); end
        if (cyc !== 18) begin n_err++; $display("FAIL post_rst_cycles got %0d want 18", cyc); end
        n_cmp += 4;
    endtask

    task automatic test_back_to_back();
        logic [7:0] ob [2][2];
        logic [7:0] data [2][2];
        int ki, no, dn;
        data[0][0] = 8'h34; data[0][1] = 8'h12; data[1][0] = 8'hFF; data[1][1] = 8'hFF;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            ki = 0; no = 0; dn = 0; ob[s][0] = 8'h00; ob[s][1] = 8'h00;
            b_start = 1;
            @(negedge clk); b_start = 0;
            for (int c = 0; c < 100; c++) begin
                if (b_done) dn++;
                if (dn > 0 && !b_busy) break;
                if (b_in_ready && ki < 2) begin b_in_valid = 1; b_in_data = data[s][ki]; ki++; end
                else b_in_valid = 0;
                b_out_ready = b_out_valid;
                if (b_out_valid && no < 2) begin ob[s][no] = b_out_data; no++; end
                @(negedge clk);
            end
            b_in_valid = 0; b_out_ready = 0;
            if (dn !== 1) begin n_err++; $display("FAIL b2b_done_count swap%0d got %0d want 1", s, dn); end
            n_cmp++;
        end
        if (ob[0][0] !== 8'h00) begin n_err++; $display("FAIL b2b_first_out0 got %h want 00", ob[0][0]); end
        if (ob[1][0] !== 8'h34) begin n_err++; $display("FAIL b2b_second_out0 got %h want 34", ob[1][0]); end
        if (ob[1][1] !== 8'h12) begin n_err++; $display("FAIL b2b_second_out1 got %h want 12", ob[1][1]); end
        if (chain_b !== 16'hFFFF) begin n_err++; $display("FAIL b2b_chain got %h want ffff", chain_b); end
        n_cmp += 4;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        test_reset();
        test_swap();
        test_backpressure();
        test_run_after();
        test_start_while_busy();
        test_reset_mid_shift();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
